// File: rtl/halut_result_collector.sv
// halut_result_collector
// Buffers the FP32 results of one decode pass and streams them to a sink over a
// valid/ready handshake. Bursts arrive from the decoder array at full rate, with
// no back-pressure, and are written into a bank. A closed bank is drained in
// index order.
//
// Configuration macro: HALUT_RESULT_COLLECTOR_PINGPONG_EN
//   defined   -> two banks (ping-pong): capture of burst N+1 overlaps drain of N
//   undefined -> one bank: a burst arriving before the bank frees is dropped
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   in_result_i/_valid_i   result beat from decoder array (no ready upstream)
//   in_m_addr_i            M-row index of the beat
//   out_data_o/_m_addr_o   buffered result and its index
//   out_last_o             final entry of the burst
//   out_valid_o/_ready_i   downstream handshake
//   clear_i                clears sticky error flags (a same-cycle set wins)
//   overflow_o             sticky: burst dropped, no free bank
//   seq_err_o              sticky: out-of-sequence beat dropped
//   busy_o                 any bank occupied or output valid
module halut_result_collector #(
  parameter int unsigned DecoderUnits = 16,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned DecAddrWidth = $clog2(DecoderUnits)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [DataWidth-1:0]    in_result_i,
  input  logic                    in_valid_i,
  input  logic [DecAddrWidth-1:0] in_m_addr_i,
  output logic [DataWidth-1:0]    out_data_o,
  output logic [DecAddrWidth-1:0] out_m_addr_o,
  output logic                    out_last_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  input  logic                    clear_i,
  output logic                    overflow_o,
  output logic                    seq_err_o,
  output logic                    busy_o
);

`ifdef HALUT_RESULT_COLLECTOR_PINGPONG_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif
  localparam int unsigned CntWidth = DecAddrWidth + 1;
  localparam logic [DecAddrWidth-1:0] LastIdx = DecAddrWidth'(DecoderUnits - 1);

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_e;

  bank_state_e             state_q [NB];
  bank_state_e             state_d [NB];
  logic [CntWidth-1:0]     count_q [NB];
  logic [CntWidth-1:0]     count_d [NB];
  logic                    wp_q, wp_d;
  logic                    rp_q, rp_d;
  logic                    wp_next, rp_next;
  logic [DecAddrWidth-1:0] rd_idx_q, rd_idx_d, rd_next;
  logic                    dropping_q, dropping_d;
  logic [DataWidth-1:0]    out_data_q, out_data_d;
  logic [DecAddrWidth-1:0] out_m_addr_q, out_m_addr_d;
  logic                    out_last_q, out_last_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overflow_q, overflow_d;
  logic                    seq_err_q, seq_err_d;
  logic                    busy_q, busy_d;
  logic                    ovf_set, seq_set;
  logic                    wr_en;

  // Result storage; contents are don't-care after reset, so no reset here.
  logic [DataWidth-1:0] mem_q [NB][DecoderUnits];

  // With a single bank both pointers stay at zero.
  assign wp_next = (NB > 1) ? ~wp_q : 1'b0;
  assign rp_next = (NB > 1) ? ~rp_q : 1'b0;
  assign rd_next = rd_idx_q + DecAddrWidth'(1);

  // Next-state: capture on bank wp, drain on bank rp, flags and busy.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      state_d[b] = state_q[b];
      count_d[b] = count_q[b];
    end
    wp_d         = wp_q;
    rp_d         = rp_q;
    rd_idx_d     = rd_idx_q;
    dropping_d   = dropping_q;
    out_data_d   = out_data_q;
    out_m_addr_d = out_m_addr_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    ovf_set      = 1'b0;
    seq_set      = 1'b0;
    wr_en        = 1'b0;
    busy_d       = 1'b0;

    // Capture. Beats of an overflowed burst are swallowed silently until an
    // index-0 beat finds a free bank.
    case (state_q[wp_q])
      BANK_FREE: begin
        if (in_valid_i) begin
          if (in_m_addr_i == '0) begin
            wr_en          = 1'b1;
            state_d[wp_q]  = BANK_FILLING;
            count_d[wp_q]  = CntWidth'(1);
            dropping_d     = 1'b0;
          end else if (!dropping_q) begin
            seq_set = 1'b1;
          end
        end
      end
      BANK_FILLING: begin
        if (!in_valid_i) begin
          state_d[wp_q] = BANK_FULL;
          wp_d          = wp_next;
        end else if (CntWidth'(in_m_addr_i) == count_q[wp_q]) begin
          wr_en         = 1'b1;
          count_d[wp_q] = count_q[wp_q] + CntWidth'(1);
          if (in_m_addr_i == LastIdx) begin
            state_d[wp_q] = BANK_FULL;
            wp_d          = wp_next;
          end
        end else begin
          seq_set = 1'b1;
        end
      end
      default: begin
        if (in_valid_i) begin
          ovf_set    = 1'b1;
          dropping_d = 1'b1;
        end
      end
    endcase

    // Drain. out_valid is high for the whole time the rp bank is DRAINING.
    case (state_q[rp_q])
      BANK_FULL: begin
        state_d[rp_q] = BANK_DRAINING;
        rd_idx_d      = '0;
        out_valid_d   = 1'b1;
        out_data_d    = mem_q[rp_q][0];
        out_m_addr_d  = '0;
        out_last_d    = (count_q[rp_q] == CntWidth'(1));
      end
      BANK_DRAINING: begin
        if (out_ready_i) begin
          if (CntWidth'(rd_idx_q) == count_q[rp_q] - CntWidth'(1)) begin
            state_d[rp_q] = BANK_FREE;
            count_d[rp_q] = '0;
            rp_d          = rp_next;
            out_valid_d   = 1'b0;
            out_last_d    = 1'b0;
          end else begin
            rd_idx_d     = rd_next;
            out_data_d   = mem_q[rp_q][rd_next];
            out_m_addr_d = rd_next;
            out_last_d   = (CntWidth'(rd_next) == count_q[rp_q] - CntWidth'(1));
          end
        end
      end
      default: ;
    endcase

    // A set event beats a simultaneous clear.
    overflow_d = ovf_set | (overflow_q & ~clear_i);
    seq_err_d  = seq_set | (seq_err_q & ~clear_i);

    busy_d = out_valid_d;
    for (int b = 0; b < NB; b++) begin
      if (state_d[b] != BANK_FREE) busy_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= BANK_FREE;
        count_q[b] <= '0;
      end
      wp_q         <= 1'b0;
      rp_q         <= 1'b0;
      rd_idx_q     <= '0;
      dropping_q   <= 1'b0;
      out_data_q   <= '0;
      out_m_addr_q <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
        count_q[b] <= count_d[b];
      end
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      rd_idx_q     <= rd_idx_d;
      dropping_q   <= dropping_d;
      out_data_q   <= out_data_d;
      out_m_addr_q <= out_m_addr_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      seq_err_q    <= seq_err_d;
      busy_q       <= busy_d;
    end
  end

  // Bank write port.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wp_q][in_m_addr_i] <= in_result_i;
  end

  assign out_data_o   = out_data_q;
  assign out_m_addr_o = out_m_addr_q;
  assign out_last_o   = out_last_q;
  assign out_valid_o  = out_valid_q;
  assign overflow_o   = overflow_q;
  assign seq_err_o    = seq_err_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/halut_result_collector.md
# halut_result_collector

Buffers the FP32 results that the multi-decoder stage emits for one decode pass, tagged with M-row index, and streams them to a downstream consumer over a valid/ready handshake. It sits directly downstream of the decoder array, which has no back-pressure input. The collector therefore absorbs each result burst at full rate and decouples it from a possibly stalling sink.

## Interface
Parameters:
- DecoderUnits, 16: results per full pass; power of two, ≥2.
- DataWidth, 32: result width in bits (FP32, passed through untouched).
- DecAddrWidth, $clog2(DecoderUnits): M-row index width.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- in_result_i  in  DataWidth  result from the decoder array.
- in_valid_i  in  1  result valid. No ready is returned upstream.
- in_m_addr_i  in  DecAddrWidth  M-row index of in_result_i.
- out_data_o  out  DataWidth  buffered result.
- out_m_addr_o  out  DecAddrWidth  M-row index of out_data_o.
- out_last_o  out  1  marks the final entry of a burst.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  sink ready.
- clear_i  in  1  clears the sticky error flags.
- overflow_o  out  1  sticky flag: a burst was dropped because no bank was free.
- seq_err_o  out  1  sticky flag: an out-of-sequence index was dropped.
- busy_o  out  1  any bank not FREE, or out_valid_o high.

## Operation
- Storage: NB banks of DecoderUnits×DataWidth registers. NB is 2 with the macro defined and 1 without it.
- Each bank has its own state: FREE → FILLING → FULL → DRAINING → FREE. Each bank also holds a count, which is its number of valid entries (1..DecoderUnits).
- Capture pointer wp selects the bank being written:
  - A valid beat with wp bank FREE opens the bank (FILLING) only if in_m_addr_i==0.
  - A valid beat with wp bank FILLING is written only if in_m_addr_i==count.
  - Every accepted beat writes the entry and increments count.
  - A beat rejected for a wrong index sets seq_err_o, and the beat is dropped.
- Burst close: FILLING → FULL when either of these holds:
  - the entry at index DecoderUnits-1 is written, or
  - in_valid_i is low while the bank is FILLING.
- On close, wp toggles (NB=2) or stays put (NB=1).
- Overflow: a valid beat that finds the wp bank FULL or DRAINING is dropped and sets overflow_o. The whole burst is dropped, including its later beats, until a beat with index 0 finds a FREE bank.
- Drain pointer rp selects the bank being read:
  - When the rp bank is FULL, it moves to DRAINING and entry 0 is loaded into the output register.
  - Each handshake (out_valid_o & out_ready_i) loads the next entry.
  - After the handshake of entry count-1, the bank returns to FREE, count is cleared, and rp toggles (NB=2).
- Output register: out_data_o, out_m_addr_o and out_last_o hold stable while out_valid_o & !out_ready_i.
  - out_m_addr_o equals the entry index.
  - out_last_o is high only for entry count-1.
- Flags:
  - overflow_o and seq_err_o stay high until clear_i.
  - If a set event and clear_i occur in the same cycle, the set wins.
- Reset, including mid-burst or mid-drain:
  - all banks FREE, all counts 0, wp=rp=0;
  - all outputs 0;
  - bank contents are not cleared and are don't-care.

## Timing
- Close on index DecoderUnits-1: the write is sampled at edge E, the bank is FULL after E, and out_valid_o rises after E+1.
- Close on in_valid_i low: the close is sampled at edge E, and out_valid_o rises after E+1.
- Throughput: one entry per cycle while out_ready_i is held high. There are no bubbles between entries of one burst.
- Bank switch (NB=2): one bubble cycle between the last entry of one bank and entry 0 of the next.
- A bank that goes DRAINING→FREE at edge E can accept index 0 at edge E+1. A beat sampled at E itself sees the bank still DRAINING.
- Capture and drain on different banks proceed in the same cycle with no interaction.

## Configuration
- HALUT_RESULT_COLLECTOR_PINGPONG_EN defined:
  - NB=2, so the next burst is captured while the previous one drains.
  - overflow occurs only when both banks are occupied.
- Macro not defined:
  - NB=1, which gives about half the area.
  - Any burst that starts before the single bank returns to FREE is dropped and sets overflow_o.

## Test plan
- Full burst: indices 0..15 on consecutive cycles, out_ready_i=1. Expect 16 outputs with indices 0..15 and data matching the inputs, out_last_o only on index 15, and out_valid_o first high 2 edges after index 15 is sampled.
- Short burst: indices 0..4, then in_valid_i low. Expect 5 outputs with out_last_o on index 4, and no flags set.
- Back-pressure: full burst with out_ready_i toggling 1,0,0,1,… Outputs hold stable while stalled, all 16 entries are delivered in order, and none are duplicated.
- Back-to-back bursts while the sink is stalled for 40 cycles:
  - Macro defined: both bursts are delivered after the stall and overflow_o stays 0.
  - Macro undefined: only the first burst is delivered and overflow_o=1.
- Sequence error: indices 0,1,3. Expect seq_err_o=1 and the burst closes after 2 entries. Asserting clear_i in the same cycle as a new error leaves the flag at 1; a clear_i on a later, error-free cycle returns it to 0.
- Reset mid-drain: assert rst_i after 3 of 16 outputs. Expect out_valid_o=0 and busy_o=0 the next cycle, and a fresh full burst is then delivered correctly.
